// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter.
// Requester A (pipeline write-back) has fixed priority over requester B
// (long-latency result mover). If B is refused for STARVE_LIMIT cycles in a
// row, the next cycle belongs to B. The winning write reaches the register
// file one cycle after its handshake. A write to register 0 is accepted but
// leaves wr_en low.
module regfile_wport_arbiter #(
  parameter int STARVE_LIMIT = 4,  // legal 1..255
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_addr,
  input  logic [31:0]      a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_addr,
  input  logic [31:0]      b_data,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic             forced,
  output logic [CNT_W-1:0] a_stall_cnt
);

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } state_t;

  // Largest value starve_cnt may hold. Reaching it while B is refused moves the FSM to FORCE_B.
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  starve_cnt;
  logic [7:0]  starve_next;
  logic        a_xfer;
  logic        b_xfer;

  // Grant decode and next state. Both readies stay low while reset is asserted.
  always_comb begin
    // NOTE: every signal this block writes gets a default first, so no path can leave one unassigned and infer a latch.
    state_next = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    if (!reset) begin
      unique case (state)
        NORMAL: begin
          if (a_valid) begin
            a_ready = 1'b1;
          end else if (b_valid) begin
            b_ready = 1'b1;
          end
          if (b_valid && !b_ready && (starve_cnt == STARVE_MAX)) begin
            state_next = FORCE_B;
          end
        end
        FORCE_B: begin
          // One cycle only: B transfers here, or it has dropped valid and nothing is granted.
          b_ready    = b_valid;
          state_next = NORMAL;
        end
        default: state_next = NORMAL;
      endcase
    end
  end

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;

  // Count consecutive refused B cycles. The count clears when B transfers or withdraws, and it saturates at STARVE_MAX.
  always_comb begin
    starve_next = starve_cnt;
    if (!b_valid || b_ready) begin
      starve_next = 8'd0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_next = starve_cnt + 8'd1;
    end
  end

  // FSM state and starvation counter registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values regardless of block order.
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= 8'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  assign forced = (state == FORCE_B);

  // Register the granted write. Address and data update even for r0. Without a transfer they hold their last values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= 32'd0;
    end else if (a_xfer) begin
      wr_en   <= (a_addr != 5'd0);
      wr_addr <= a_addr;
      wr_data <= a_data;
    end else if (b_xfer) begin
      wr_en   <= (b_addr != 5'd0);
      wr_addr <= b_addr;
      wr_data <= b_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Saturating count of cycles in which A waits for the port.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_stall_cnt <= '0;
    end else if (a_valid && !a_ready && (a_stall_cnt != '1)) begin
      a_stall_cnt <= a_stall_cnt + CNT_W'(1);
    end
  end

endmodule
